// File: rtl/addsub_arbiter_if.sv
// ---------------------------------------------------------------------------
// addsub_arbiter_if
// Bundles the two requester ports and the response port of addsub_arbiter.
//
// Signals
//   req0_valid/ready, req0_a, req0_b, req0_sel : requester port 0
//   req1_valid/ready, req1_a, req1_b, req1_sel : requester port 1
//   rsp_valid/ready, rsp_id, rsp_sum, rsp_cout : result port
//   op_count                                   : completed responses, mod 256
//
// Modports
//   master : requesters and result consumer (drives valids/operands/rsp_ready)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface addsub_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req0_sel;

    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req1_sel;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_sum;
    logic       rsp_cout;
    logic [7:0] op_count;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, op_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, op_count
    );
endinterface

// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter
// Two requesters share one 4-bit adder/subtractor. At most one operation is
// in flight: IDLE grants a port and captures its operands, EXEC runs the
// datapath, RESP presents the result until the consumer takes it.
//
// Parameters
//   RR_EN : 1 = round-robin on ties, 0 = port 0 always wins ties
//
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : addsub_arbiter_if.slave (request ports, response port, op_count)
// ---------------------------------------------------------------------------
module addsub_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input logic             clk,
    input logic             rst,
    addsub_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] opa_q, opa_d;
    logic [3:0] opb_q, opb_d;
    logic       op_sel_q, op_sel_d;
    logic       op_id_q, op_id_d;
    logic [3:0] rsp_sum_q, rsp_sum_d;
    logic       rsp_cout_q, rsp_cout_d;
    logic       rsp_id_q, rsp_id_d;
    logic [7:0] op_count_q, op_count_d;
    logic       last_grant_q, last_grant_d;

    logic       any_valid;
    logic       grant_id;
    logic       req0_ready_c;
    logic       req1_ready_c;
    logic [4:0] dp_result;

    // Pick which port would win if we accept this cycle. On a tie the
    // round-robin variant favours the port that did not win last time;
    // last_grant resets to 1 so port 0 takes the very first tie.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = RR_EN ? ~last_grant_q : 1'b0;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Shared datapath: subtraction is A + ~B + 1, so cout=1 means no borrow.
    always_comb begin
        dp_result = {1'b0, opa_q}
                  + {1'b0, (opb_q ^ {4{op_sel_q}})}
                  + {4'b0000, op_sel_q};
    end

    // Next-state and handshake logic. Readies are only ever raised in IDLE
    // and are held low while rst is asserted so nothing is accepted into a
    // cycle that is about to be wiped.
    always_comb begin
        state_d      = state_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_sel_d     = op_sel_q;
        op_id_d      = op_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_id_d     = rsp_id_q;
        op_count_d   = op_count_q;
        last_grant_d = last_grant_q;
        req0_ready_c = 1'b0;
        req1_ready_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid && !rst) begin
                    req0_ready_c = ~grant_id;
                    req1_ready_c = grant_id;
                    opa_d        = grant_id ? bus.req1_a   : bus.req0_a;
                    opb_d        = grant_id ? bus.req1_b   : bus.req0_b;
                    op_sel_d     = grant_id ? bus.req1_sel : bus.req0_sel;
                    op_id_d      = grant_id;
                    last_grant_d = grant_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_sum_d  = dp_result[3:0];
                rsp_cout_d = dp_result[4];
                rsp_id_d   = op_id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset aborts any in-flight operation outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            opa_q        <= 4'd0;
            opb_q        <= 4'd0;
            op_sel_q     <= 1'b0;
            op_id_q      <= 1'b0;
            rsp_sum_q    <= 4'd0;
            rsp_cout_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            op_count_q   <= 8'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_sel_q     <= op_sel_d;
            op_id_q      <= op_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_id_q     <= rsp_id_d;
            op_count_q   <= op_count_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req0_ready = req0_ready_c;
    assign bus.req1_ready = req1_ready_c;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_addsub_arbiter
// Drives a round-robin instance and a fixed-priority instance with identical
// stimulus. Known vectors come from a table, multi-cycle corner cases are
// hand-written, and a long random run is compared against a transaction-level
// model of the arbiter.
// ---------------------------------------------------------------------------
module tb_addsub_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    addsub_arbiter_if rr_bus ();
    addsub_arbiter_if fp_bus ();

    addsub_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(rr_bus));
    addsub_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(fp_bus));

    typedef struct {
        logic       v0;
        logic [3:0] a0;
        logic [3:0] b0;
        logic       s0;
        logic       v1;
        logic [3:0] a1;
        logic [3:0] b1;
        logic       s1;
        logic       exp_id;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Both instances always see the same request/consumer inputs.
    task automatic driveInputs(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic s0, input logic v1, input logic [3:0] a1,
                               input logic [3:0] b1, input logic s1, input logic rdy);
        rr_bus.req0_valid = v0; rr_bus.req0_a = a0; rr_bus.req0_b = b0; rr_bus.req0_sel = s0;
        rr_bus.req1_valid = v1; rr_bus.req1_a = a1; rr_bus.req1_b = b1; rr_bus.req1_sel = s1;
        rr_bus.rsp_ready  = rdy;
        fp_bus.req0_valid = v0; fp_bus.req0_a = a0; fp_bus.req0_b = b0; fp_bus.req0_sel = s0;
        fp_bus.req1_valid = v1; fp_bus.req1_a = a1; fp_bus.req1_b = b1; fp_bus.req1_sel = s1;
        fp_bus.rsp_ready  = rdy;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One table transaction on the round-robin instance, with exact latency.
    task automatic applyStimulus(input vec_t v, input int exp_count);
        @(negedge clk);
        driveInputs(v.v0, v.a0, v.b0, v.s0, v.v1, v.a1, v.b1, v.s1, 1'b1);
        #1;
        checkOutput("tbl_ready_granted", v.exp_id ? rr_bus.req1_ready : rr_bus.req0_ready, 1);
        checkOutput("tbl_ready_other", v.exp_id ? rr_bus.req0_ready : rr_bus.req1_ready, 0);
        @(negedge clk);
        driveInputs(0, 4'hf, 4'hf, 1, 0, 4'hf, 4'hf, 1, 1'b1);
        checkOutput("tbl_exec_valid", rr_bus.rsp_valid, 0);
        @(negedge clk);
        checkOutput("tbl_rsp_valid", rr_bus.rsp_valid, 1);
        checkOutput("tbl_rsp_sum", rr_bus.rsp_sum, v.exp_sum);
        checkOutput("tbl_rsp_cout", rr_bus.rsp_cout, v.exp_cout);
        checkOutput("tbl_rsp_id", rr_bus.rsp_id, v.exp_id);
        @(negedge clk);
        checkOutput("tbl_done_valid", rr_bus.rsp_valid, 0);
        checkOutput("tbl_op_count", rr_bus.op_count, exp_count);
    endtask

    // Reference arithmetic: plain add or subtract of unsigned nibbles.
    function automatic logic [4:0] refCalc(input int a, input int b, input logic sel);
        int r;
        logic c;
        if (sel) begin
            r = a - b;
            c = (a >= b);
        end else begin
            r = a + b;
            c = (r > 15);
        end
        return {c, 4'(r & 15)};
    endfunction

    // Hard stop if something wedges the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic q_rr[$];
        logic q_fp[$];
        logic exp_rr[4];
        logic exp_fp[4];
        logic [4:0] r;

        vecs[0] = '{1'b1, 4'd5,  4'd3, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8,  1'b0};
        vecs[1] = '{1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd14, 1'b0};
        vecs[2] = '{1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b1, 4'd2,  1'b1};
        vecs[3] = '{1'b1, 4'd7,  4'd2, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5,  1'b1};
        vecs[4] = '{1'b1, 4'd15, 4'd1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0,  1'b1};
        vecs[5] = '{1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0,  1'b1};
        vecs[6] = '{1'b1, 4'd1,  4'd1, 1'b0, 1'b1, 4'd4, 4'd1, 1'b1, 1'b0, 4'd2,  1'b0};
        vecs[7] = '{1'b1, 4'd2,  4'd2, 1'b0, 1'b1, 4'd6, 4'd3, 1'b1, 1'b1, 4'd3,  1'b1};

        // Reset with both requesters shouting: no ready may leak out.
        rst = 1'b1;
        driveInputs(1, 4'd1, 4'd2, 0, 1, 4'd3, 4'd4, 0, 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_ready0_rr", rr_bus.req0_ready, 0);
        checkOutput("rst_ready1_rr", rr_bus.req1_ready, 0);
        checkOutput("rst_ready0_fp", fp_bus.req0_ready, 0);
        checkOutput("rst_ready1_fp", fp_bus.req1_ready, 0);
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_rsp_valid", rr_bus.rsp_valid, 0);
        checkOutput("rst_rsp_sum", rr_bus.rsp_sum, 0);
        checkOutput("rst_rsp_cout", rr_bus.rsp_cout, 0);
        checkOutput("rst_rsp_id", rr_bus.rsp_id, 0);
        checkOutput("rst_op_count", rr_bus.op_count, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i + 1);
        end

        // Backpressure: port 0 wins the tie, consumer stalls five cycles.
        $display("[TB] backpressure sequence");
        @(negedge clk);
        driveInputs(1, 4'd6, 4'd7, 0, 1, 4'd2, 4'd2, 1, 0);
        #1;
        checkOutput("bp_ready0", rr_bus.req0_ready, 1);
        checkOutput("bp_ready1", rr_bus.req1_ready, 0);
        @(negedge clk);
        checkOutput("bp_exec_ready0", rr_bus.req0_ready, 0);
        checkOutput("bp_exec_ready1", rr_bus.req1_ready, 0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_valid", rr_bus.rsp_valid, 1);
            checkOutput("bp_sum", rr_bus.rsp_sum, 13);
            checkOutput("bp_cout", rr_bus.rsp_cout, 0);
            checkOutput("bp_id", rr_bus.rsp_id, 0);
            checkOutput("bp_no_ready", {rr_bus.req0_ready, rr_bus.req1_ready}, 0);
            @(negedge clk);
        end
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("bp_release_valid", rr_bus.rsp_valid, 1);
        @(negedge clk);
        checkOutput("bp_done_valid", rr_bus.rsp_valid, 0);
        checkOutput("bp_op_count", rr_bus.op_count, 9);

        // Reset while the operation sits in EXEC.
        $display("[TB] reset during EXEC");
        @(negedge clk);
        driveInputs(0, 0, 0, 0, 1, 4'd3, 4'd5, 1, 1);
        @(negedge clk);
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_valid", rr_bus.rsp_valid, 0);
        checkOutput("abort_op_count", rr_bus.op_count, 0);
        @(negedge clk);
        checkOutput("abort_still_idle", rr_bus.rsp_valid, 0);
        applyStimulus(vecs[0], 1);

        // Both valid continuously: grant order per arbitration mode.
        $display("[TB] grant order sequence");
        pulseReset();
        driveInputs(1, 4'd1, 4'd2, 0, 1, 4'd3, 4'd4, 0, 1);
        for (int cyc = 0; cyc < 30; cyc++) begin
            #1;
            checkOutput("rr_excl", rr_bus.req0_ready & rr_bus.req1_ready, 0);
            checkOutput("fp_excl", fp_bus.req0_ready & fp_bus.req1_ready, 0);
            if (rr_bus.req0_ready) q_rr.push_back(1'b0);
            if (rr_bus.req1_ready) q_rr.push_back(1'b1);
            if (fp_bus.req0_ready) q_fp.push_back(1'b0);
            if (fp_bus.req1_ready) q_fp.push_back(1'b1);
            @(negedge clk);
            if (q_rr.size() >= 4 && q_fp.size() >= 4) break;
        end
        checkOutput("rr_grant_count", (q_rr.size() >= 4) ? 4 : q_rr.size(), 4);
        checkOutput("fp_grant_count", (q_fp.size() >= 4) ? 4 : q_fp.size(), 4);
        exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_fp = '{1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i < q_rr.size()) checkOutput("rr_grant_order", q_rr[i], exp_rr[i]);
            if (i < q_fp.size()) checkOutput("fp_grant_order", q_fp[i], exp_fp[i]);
        end
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) @(negedge clk);

        // 257 back-to-back operations wrap op_count to 1.
        $display("[TB] wrap-around sequence");
        pulseReset();
        driveInputs(1, 4'd1, 4'd1, 0, 0, 0, 0, 0, 1);
        repeat (765) @(negedge clk);
        checkOutput("wrap_count_255", rr_bus.op_count, 255);
        repeat (3) @(negedge clk);
        checkOutput("wrap_count_0", rr_bus.op_count, 0);
        repeat (3) @(negedge clk);
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("wrap_count_1", rr_bus.op_count, 1);
        @(negedge clk);
        checkOutput("wrap_idle_valid", rr_bus.rsp_valid, 0);
        checkOutput("wrap_count_hold", rr_bus.op_count, 1);

        // Random traffic against a transaction-level model.
        $display("[TB] random sequence");
        pulseReset();
        begin
            logic       m_busy  = 1'b0;
            int         m_age   = 0;
            logic       m_last  = 1'b1;
            int         m_count = 0;
            logic       m_id    = 1'b0;
            logic [4:0] m_res   = 5'd0;
            logic       v0, v1, s0, s1, rdy, g, exp_r0, exp_r1, exp_v;
            logic [3:0] a0, b0, a1, b1;
            for (int cyc = 0; cyc < 400; cyc++) begin
                v0 = 1'($urandom_range(0, 1));
                v1 = 1'($urandom_range(0, 1));
                a0 = 4'($urandom_range(0, 15));
                b0 = 4'($urandom_range(0, 15));
                a1 = 4'($urandom_range(0, 15));
                b1 = 4'($urandom_range(0, 15));
                s0 = 1'($urandom_range(0, 1));
                s1 = 1'($urandom_range(0, 1));
                rdy = ($urandom_range(0, 3) != 0);
                driveInputs(v0, a0, b0, s0, v1, a1, b1, s1, rdy);
                #1;
                g      = (v0 && v1) ? !m_last : v1;
                exp_r0 = !m_busy && (v0 || v1) && (g == 1'b0);
                exp_r1 = !m_busy && (v0 || v1) && (g == 1'b1);
                exp_v  = m_busy && (m_age >= 1);
                checkOutput("rnd_ready0", rr_bus.req0_ready, exp_r0);
                checkOutput("rnd_ready1", rr_bus.req1_ready, exp_r1);
                checkOutput("rnd_rsp_valid", rr_bus.rsp_valid, exp_v);
                checkOutput("rnd_op_count", rr_bus.op_count, m_count);
                if (exp_v) begin
                    checkOutput("rnd_rsp_id", rr_bus.rsp_id, m_id);
                    checkOutput("rnd_rsp_sum", rr_bus.rsp_sum, m_res[3:0]);
                    checkOutput("rnd_rsp_cout", rr_bus.rsp_cout, m_res[4]);
                end
                if (!m_busy) begin
                    if (v0 || v1) begin
                        m_id   = g;
                        m_res  = g ? refCalc(int'(a1), int'(b1), s1) : refCalc(int'(a0), int'(b0), s0);
                        m_last = g;
                        m_busy = 1'b1;
                        m_age  = 0;
                    end
                end else if (m_age == 0) begin
                    m_age = 1;
                end else if (rdy) begin
                    m_count = (m_count + 1) % 256;
                    m_busy  = 1'b0;
                end
                @(negedge clk);
            end
        end
        r = refCalc(0, 0, 0);
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, r[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
